uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  Serialises one parallel byte per request into an 8N1-style UART frame on Tx.
//  Shares the 16x-oversample clken tick with the receiver, so one baud generator drives both ends.
//  Optional parity and a second stop bit are selected by parameter.
//  Sits between the host write port and the Tx pin; its Tx loops back to the receiver's Rx in test.
// PARAMETERS
//  DATA_BITS   8  number of data bits per frame (5..8), sent LSB first
//  PARITY_EN   0  1 = insert parity bit after data
//  PARITY_ODD  0  parity sense when PARITY_EN=1: 0 = even, 1 = odd
//  STOP_BITS   1  number of stop bits (1 or 2)
// PORTS
//  clk_50m   in   1          system clock, all logic on posedge
//  rst       in   1          asynchronous reset, active-high
//  clken     in   1          16x baud tick, one clk_50m cycle wide
//  wr_en     in   1          request to send din; accepted only when busy==0
//  din       in   DATA_BITS  byte to send, sampled on the accepting cycle
//  Tx        out  1          serial line, idles high
//  busy      out  1          high from cycle after acceptance until frame end
//  tx_done   out  1          one-cycle pulse when last stop bit completes
// BEHAVIOUR
//  Reset (async, rst=1): Tx=1, busy=0, tx_done=0, state=IDLE, tick and bit counters=0, shift reg=0.
//  All outputs are registered; no combinational path from inputs to outputs.
//  Accept: wr_en=1 && busy==0 on a clk edge -> latch din, compute parity, state=START, busy=1, Tx=0, tick=0.
//   Acceptance does not wait for clken.
//  wr_en while busy=1 is ignored; din is not re-sampled and there is no queue.
//  Bit timing: each bit holds Tx for exactly 16 clken ticks. 4-bit tick counter increments on clken only.
//   On the clken where tick==15, tick wraps to 0 and the FSM advances.
//  FSM: IDLE -> START (Tx=0) -> DATA (Tx=shift[0], DATA_BITS bits) -> [PARITY] -> STOP (Tx=1, STOP_BITS bits) -> IDLE.
//   DATA: shift right after each bit; bit counter 0..DATA_BITS-1, leaves DATA when count==DATA_BITS-1 and tick==15.
//   PARITY state exists only if PARITY_EN=1; Tx = ^data XOR PARITY_ODD.
//   STOP: stop counter 0..STOP_BITS-1. On final tick: state=IDLE, busy=0, tx_done=1 for one cycle, Tx stays 1.
//  Back-to-back: wr_en on the cycle tx_done=1 (busy already 0) is accepted.
//   The next start bit begins on the following cycle, with no extra idle ticks.
//  clken=0 forever: the FSM stalls mid-bit with Tx held, and busy stays high.
//  Reset mid-frame aborts immediately: Tx returns high asynchronously, and no tx_done is generated.
//  Illegal/unused state encodings recover to IDLE with Tx=1 on the next clk.
//  Frame length in clken ticks = 16*(1 + DATA_BITS + PARITY_EN + STOP_BITS). Default: 160 ticks.
// STRUCTURE
//  Shared package uart_pkg holds:
//   - TICKS_PER_BIT=16
//   - FSM state localparams: IDLE, START, DATA, PARITY, STOP (3-bit encoding)
//   - the parity-sense constants
//  The receiver should migrate to the same package.
//  No sub-module. The baud/clken generator is external (uart_baud_gen, shared with receiver), not instantiated here.
//  Registers: state, tick[3:0], bit_cnt[$clog2(DATA_BITS)-1:0], stop_cnt, shift[DATA_BITS-1:0], par_bit, Tx, busy, tx_done.
// TESTING
//  1. Reset, then idle 500 cycles with clken running -> Tx=1, busy=0, tx_done never pulses.
//  2. Default params, send 8'hA5 -> Tx sequence 0,1,0,1,0,0,1,0,1,1 at 16 ticks each.
//     busy high for 160 ticks; one tx_done pulse.
//  3. Loopback Tx->receiver Rx, send 8'h00, 8'hFF, 8'h55 back-to-back on tx_done -> receiver data matches each.
//     Receiver ready asserts 3 times; no idle gap between frames.
//  4. PARITY_EN=1: send 8'h07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
//     STOP_BITS=2 -> stop high for 32 ticks.
//  5. wr_en with din=8'h3C pulsed mid-frame while busy -> ignored; the original byte completes unchanged.
//  6. Assert rst during data bit 3 -> Tx=1 with no clk edge, busy=0; a new 8'h81 after reset is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio, transmit FSM encoding, parity sense.
// Intended to be imported by both the transmitter and the receiver.
package uart_pkg;

  localparam int TICKS_PER_BIT = 16;

  localparam bit PARITY_SENSE_EVEN = 1'b0;
  localparam bit PARITY_SENSE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per accepted request, LSB first, optional parity and
// second stop bit, paced by the shared 16x clken tick. All outputs registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  output logic                 Tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int            BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [3:0]    TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_SENSE = 1'(PARITY_ODD);

  tx_state_e              r_state,    w_state;
  logic [3:0]             r_tick,     w_tick;
  logic [BW-1:0]          r_bit_cnt,  w_bit_cnt;
  logic                   r_stop_cnt, w_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift,    w_shift;
  logic                   r_par,      w_par;
  logic                   r_tx,       w_tx;
  logic                   r_busy,     w_busy;
  logic                   r_done,     w_done;
  logic                   w_bit_end;

  assign w_bit_end = clken && (r_tick == TICK_LAST);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick     <= w_tick;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_shift    <= w_shift;
      r_par      <= w_par;
      r_tx       <= w_tx;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tick     = r_tick;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_shift    = r_shift;
    w_par      = r_par;
    w_tx       = r_tx;
    w_busy     = r_busy;
    w_done     = 1'b0;

    // Tick wraps 15->0 by width; the bit boundary is the wrapping clken.
    if (clken && r_state != IDLE) w_tick = r_tick + 4'd1;

    case (r_state)
      IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        w_tick = '0;
        if (wr_en && !r_busy) begin
          w_shift    = din;
          w_par      = (^din) ^ PAR_SENSE;
          w_state    = START;
          w_busy     = 1'b1;
          w_tx       = 1'b0;
          w_bit_cnt  = '0;
          w_stop_cnt = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state   = DATA;
          w_bit_cnt = '0;
          w_tx      = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift = r_shift >> 1;
          if (r_bit_cnt == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              w_state = PARITY;
              w_tx    = r_par;
            end else begin
              w_state    = STOP;
              w_tx       = 1'b1;
              w_stop_cnt = 1'b0;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + BW'(1);
            w_tx      = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (PARITY_EN == 0) begin
          w_state = IDLE;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
          w_tick  = '0;
        end else if (w_bit_end) begin
          w_state    = STOP;
          w_tx       = 1'b1;
          w_stop_cnt = 1'b0;
        end
      end
      STOP: begin
        w_tx = 1'b1;
        if (w_bit_end) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_stop_cnt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_tick  = '0;
      end
    endcase
  end

  assign Tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench: default framing, back-to-back frames, parity/stop variants,
// ignored mid-frame writes and asynchronous reset abort.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clken = 1'b0;
  logic [2:0] wr = 3'b000;
  logic [7:0] din = 8'h00;
  logic [2:0] tx, busy, done;

  int   ntest = 0;
  int   nfail = 0;
  int   ndone = 0;
  logic [1:0] div = 2'd0;
  logic       pre_ck;
  logic [2:0] pre_tx, pre_busy;

  always #5 clk = ~clk;

  // u0 default 8N1, u1 even parity + 2 stop, u2 odd parity + 1 stop
  uart_transmitter u0 (.clk_50m(clk), .rst(rst), .clken(clken), .wr_en(wr[0]), .din(din),
                       .Tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
                       .clk_50m(clk), .rst(rst), .clken(clken), .wr_en(wr[1]), .din(din),
                       .Tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
                       .clk_50m(clk), .rst(rst), .clken(clken), .wr_en(wr[2]), .din(din),
                       .Tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: clken pulses every 4th cycle; pre_* hold values seen by the edge.
  task automatic cyc();
    clken    = (div == 2'd3);
    div      = div + 2'd1;
    pre_ck   = clken;
    pre_tx   = tx;
    pre_busy = busy;
    @(posedge clk);
    #1;
  endtask

  // Send d on DUT sel, sample Tx on every clken while busy, rebuild the frame word
  // (bit k = k-th serial bit) and check it against exp.
  task automatic frame(input int sel, input logic [7:0] d, input int nbits, input int inj,
                       input string tag, input logic [15:0] exp);
    logic        smp [0:255];
    int          ns = 0;
    int          n = 0;
    logic [15:0] w = '0;
    bit          cons = 1'b1;
    bit          to = 1'b1;
    din = d; wr[sel] = 1'b1; cyc(); wr[sel] = 1'b0;
    chk({tag, ".acc_busy"}, 32'(busy[sel]), 32'd1);
    chk({tag, ".start_tx"}, 32'(tx[sel]), 32'd0);
    while (n < 1000) begin
      if (n == inj) begin din = 8'h3C; wr[sel] = 1'b1; end
      cyc(); wr[sel] = 1'b0; n++;
      if (pre_ck && pre_busy[sel] && ns < 256) begin smp[ns] = pre_tx[sel]; ns++; end
      if (done[sel]) begin ndone++; to = 1'b0; break; end
    end
    chk({tag, ".timeout"}, 32'(to), 32'd0);
    chk({tag, ".ticks"}, ns, 16 * nbits);
    for (int k = 0; k < nbits; k++) begin
      for (int j = 1; j < 16; j++) if (smp[16*k+j] !== smp[16*k]) cons = 1'b0;
      w[k] = smp[16*k];
    end
    chk({tag, ".bit_stable"}, 32'(cons), 32'd1);
    chk({tag, ".word"}, 32'(w), 32'(exp));
  endtask

  initial begin
    int bad;
    int n;
    int nd;

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst.tx", 32'(tx), 32'h7);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    repeat (3) cyc();
    rst = 1'b0;

    // idle with clken running
    bad = 0;
    repeat (500) begin
      cyc();
      if (tx !== 3'b111 || busy !== 3'b000 || done !== 3'b000) bad++;
    end
    chk("idle.violations", bad, 0);

    // default 8N1, 0xA5
    frame(0, 8'hA5, 10, -1, "a5", 16'h34A);
    cyc();
    chk("a5.single_done", 32'(done[0]), 32'd0);
    chk("a5.idle_tx", 32'(tx[0]), 32'd1);
    chk("a5.idle_busy", 32'(busy[0]), 32'd0);

    // back-to-back on tx_done
    nd = ndone;
    frame(0, 8'h00, 10, -1, "b2b_00", 16'h200);
    frame(0, 8'hFF, 10, -1, "b2b_ff", 16'h3FE);
    frame(0, 8'h55, 10, -1, "b2b_55", 16'h2AA);
    chk("b2b.done_count", ndone - nd, 3);
    cyc();
    chk("b2b.done_low", 32'(done[0]), 32'd0);

    // parity: 0x07 has three ones
    frame(1, 8'h07, 12, -1, "par_even_2stop", 16'hE0E);
    frame(2, 8'h07, 11, -1, "par_odd", 16'h40E);

    // write while busy is ignored
    frame(0, 8'h96, 10, 200, "busy_wr", 16'h32C);
    repeat (5) cyc();

    // reset during data bit 3
    din = 8'h00; wr[0] = 1'b1; cyc(); wr[0] = 1'b0;
    bad = 0; n = 0;
    while (bad < 72 && n < 1000) begin cyc(); n++; if (pre_ck) bad++; end
    chk("abort.reach_bit3", bad, 72);
    chk("abort.tx_before", 32'(tx[0]), 32'd0);
    chk("abort.busy_before", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.tx_async", 32'(tx[0]), 32'd1);
    chk("abort.busy_async", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin cyc(); if (done[0] !== 1'b0 || tx[0] !== 1'b1) bad++; end
    chk("abort.quiet", bad, 0);
    frame(0, 8'h81, 10, -1, "post_rst", 16'h302);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
